// File: rtl/priority_event_decoder_pkg.sv
// Shared definitions for the priority event decoder: default code width
// and the grant FSM state encoding.
package priority_event_decoder_pkg;

    // Default code width; the event count is 1 << PED_CW.
    localparam int PED_CW = 3;

    // Grant FSM: IDLE picks the next pending event, GRANT waits for ack.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/priority_event_decoder_pick.sv
// Combinational highest-index picker: returns a one-hot vector of the
// highest set bit of req (bit N-1 has top priority) and an any-set flag.
module priority_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         any_o
);

    logic found_s;

    // Scan from the top bit down and keep only the first set bit found.
    always_comb begin
        gnt_o   = {N{1'b0}};
        found_s = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k] && !found_s) begin
                gnt_o[k] = 1'b1;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        any_o = found_s;
    end

endmodule

// File: rtl/priority_event_decoder.sv
// Receive side of the priority encoder {o, v} interface. Decoded codes are
// latched into a sticky pending register and served one at a time, highest
// index first, over a grant/ack handshake. All outputs are registered.
module priority_event_decoder
    import priority_event_decoder_pkg::*;
#(
    parameter int CW = PED_CW,
    localparam int N = 1 << CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] i,
    input  logic          v,
    input  logic          ack,
    output logic [N-1:0]  o,
    output logic          o_valid,
    output logic [N-1:0]  pending,
    output logic          overflow
);

    localparam logic [N-1:0] ONE_N = {{(N - 1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] o_q, o_d;
    logic         o_valid_q, o_valid_d;
    logic         overflow_q, overflow_d;

    logic [N-1:0] set_s;
    logic [N-1:0] clear_s;
    logic [N-1:0] pick_s;
    logic         pick_any_s;

    priority_pick #(
        .N (N)
    ) u_pick (
        .req_i (pending_q),
        .gnt_o (pick_s),
        .any_o (pick_any_s)
    );

    // Grant FSM: pick the top pending event in IDLE, hold it in GRANT until ack.
    always_comb begin
        state_d   = state_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        clear_s   = {N{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    o_d       = pick_s;
                    o_valid_d = 1'b1;
                    state_d   = ST_GRANT;
                end else begin
                    o_d       = {N{1'b0}};
                    o_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    clear_s   = o_q;
                    o_d       = {N{1'b0}};
                    o_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_GRANT;
                end
            end
            default: begin
                o_d       = {N{1'b0}};
                o_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Capture: a new code sets its pending bit (set beats a same-cycle clear);
    // a code whose bit is already pending and not being cleared is lost.
    always_comb begin
        set_s      = {N{1'b0}};
        overflow_d = 1'b0;
        if (en && v) begin
            set_s      = ONE_N << i;
            overflow_d = pending_q[i] && !clear_s[i];
        end else begin
            set_s      = {N{1'b0}};
            overflow_d = 1'b0;
        end
        pending_d = (pending_q & ~clear_s) | set_s;
    end

    // State, pending and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= {N{1'b0}};
            o_q        <= {N{1'b0}};
            o_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_priority_event_decoder.sv
// Scoreboard bench for priority_event_decoder: a behavioural model predicts
// per-cycle outputs and the order of grants; a monitor compares on the
// falling edge.
module tb_priority_event_decoder;

    localparam int CW = 3;
    localparam int N  = 8;

    typedef struct {
        logic [N-1:0] pending;
        logic [N-1:0] o;
        logic         o_valid;
        logic         overflow;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] i = '0;
    logic          v = 1'b0;
    logic          ack = 1'b0;
    logic [N-1:0]  o;
    logic          o_valid;
    logic [N-1:0]  pending;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];
    int   grant_q[$];

    // Reference model state: pending events as an array of flags and the
    // index currently granted (-1 when nothing is granted).
    bit m_pend[N];
    int m_cur = -1;

    priority_event_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .i        (i),
        .v        (v),
        .ack      (ack),
        .o        (o),
        .o_valid  (o_valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k] = m_pend[k];
        return r;
    endfunction

    function automatic int highest_pending();
        for (int k = N - 1; k >= 0; k--) if (m_pend[k]) return k;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs driven for it.
    task automatic model_edge();
        exp_t e;
        int   top;
        bit   acked;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
            m_cur = -1;
            e.overflow = 1'b0;
        end else begin
            acked = (m_cur >= 0) && ack;
            top   = highest_pending();
            e.overflow = en && v && m_pend[i] && !(acked && m_cur == int'(i));
            if (acked) m_pend[m_cur] = 1'b0;
            if (en && v) m_pend[i] = 1'b1;
            if (m_cur >= 0) begin
                if (acked) m_cur = -1;
            end else if (top >= 0) begin
                m_cur = top;
                grant_q.push_back(top);
            end
        end
        e.pending = pend_vec();
        e.o_valid = (m_cur >= 0);
        e.o       = (m_cur >= 0) ? (8'd1 << m_cur) : 8'd0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic e_i, input logic v_i,
                        input int idx, input logic a_i);
        @(negedge clk);
        rst_n = r;
        en    = e_i;
        v     = v_i;
        i     = idx[CW-1:0];
        ack   = a_i;
        @(posedge clk);
        model_edge();
    endtask

    // Monitor: compare every predicted cycle, and check grant order whenever
    // a new grant appears.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pending", 32'(pending), 32'(e.pending));
            chk("o", 32'(o), 32'(e.o));
            chk("o_valid", 32'(o_valid), 32'(e.o_valid));
            chk("overflow", 32'(overflow), 32'(e.overflow));
            chk("onehot_or_zero", 32'(($countones(o) == 0 && !o_valid) ||
                                      ($countones(o) == 1 && o_valid)), 32'd1);
        end
        if (o_valid && !prev_valid) begin
            if (grant_q.size() > 0) begin
                g = grant_q.pop_front();
                chk("grant_order", 32'(o), 32'(8'd1 << g));
            end else begin
                chk("unexpected_grant", 32'(o), 32'd0);
            end
        end
        prev_valid = o_valid;
    end

    initial begin
        // Reset held with idle inputs.
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Single event 3, acked on the first cycle it is granted.
        step(1'b1, 1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Codes 2, 6, 0 back to back with ack held high.
        step(1'b1, 1'b1, 1'b1, 2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 6, 1'b1);
        step(1'b1, 1'b1, 1'b1, 0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Grant for 2 held; a higher event 7 does not preempt it.
        step(1'b1, 1'b1, 1'b1, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 7, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Repeated 5 while pending (overflow), then 5 on its own ack cycle.
        step(1'b1, 1'b1, 1'b1, 7, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Capture disabled: no event from a valid code.
        step(1'b1, 1'b0, 1'b1, 4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4, 1'b0);

        // Asynchronous reset in the middle of a grant.
        step(1'b1, 1'b1, 1'b1, 6, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_o", 32'(o), 32'd0);
        chk("async_rst_valid", 32'(o_valid), 32'd0);
        chk("async_rst_pending", 32'(pending), 32'd0);
        @(posedge clk);
        model_edge();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Randomised traffic with random acks.
        for (int n = 0; n < 600; n++) begin
            step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, N - 1)), ($urandom_range(0, 2) == 0));
        end

        // Drain everything that is still pending.
        repeat (40) step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("grants_all_seen", 32'(grant_q.size()), 32'd0);
        chk("drained_pending", 32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
